sched_value_driver: RTL

//  Synthesizable delayed-value driver for a set-value request stream.

---
 rtl/sched_value_driver.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sched_value_driver.sv
`default_nettype none
// ============================================================================
// Module   : sched_value_driver
// Purpose  : Delayed-value driver. Timed set-value requests are held in a small
//            pending-event queue and written to one WIDTH-bit net on schedule.
//            Optional force/release override is built when SCHED_FORCE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module sched_value_driver #(
    parameter int               WIDTH     = 32,
    parameter int               DLY_W     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_mode,
    input  logic [WIDTH-1:0] req_value,
    input  logic [DLY_W-1:0] req_delay,
    output logic [WIDTH-1:0] out_val,
    output logic             pend,
    output logic             forced,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] MODE_NODELAY   = 3'd0;
    localparam logic [2:0] MODE_INERTIAL  = 3'd1;
    localparam logic [2:0] MODE_TRANSPORT = 3'd2;
    localparam logic [2:0] MODE_CANCEL    = 3'd3;
    localparam logic [2:0] MODE_FORCE     = 3'd4;
    localparam logic [2:0] MODE_RELEASE   = 3'd5;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);

    // Each entry's rem is the number of cycles until its value is visible;
    // non-head entries saturate at 1 so same-cycle ties drain one per edge.
    logic [WIDTH-1:0] val_q [DEPTH];
    logic [DLY_W-1:0] rem_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] wr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] sched_val;

    logic             fire;
    logic             accept;
    logic             late;
    logic             direct;
    logic [PTR_W-1:0] head_pp;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_pp;
    logic [DLY_W-1:0] d_eff;
    logic [DLY_W-1:0] rem_init;
    logic [DLY_W-1:0] tail_next;

    assign fire      = (count != '0) && (rem_q[head] == DLY_ONE);
    assign head_pp   = head + PTR_W'(fire);
    assign count_pp  = count - CNT_W'(fire);
    assign tail      = wr - PTR_ONE;
    assign tail_next = (rem_q[tail] > DLY_ONE) ? (rem_q[tail] - DLY_ONE) : DLY_ONE;
    assign d_eff     = (req_delay == '0) ? DLY_ONE : req_delay;
    assign rem_init  = (d_eff == DLY_ONE) ? DLY_ONE : (d_eff - DLY_ONE);

    assign req_ready = (count != FULL_CNT) || (req_mode != MODE_TRANSPORT);
    assign accept    = req_valid && req_ready;
    // Transport may not overtake the tail of the post-pop queue.
    assign late      = (count_pp != '0) && (d_eff < tail_next);
    // A one-cycle event with nothing ahead of it is written straight through,
    // unless the head already owns this edge.
    assign direct    = (d_eff == DLY_ONE) && !fire;
    assign pend      = (count != '0);

`ifdef SCHED_FORCE_EN
    logic             forced_q;
    logic [WIDTH-1:0] force_val;

    assign forced  = forced_q;
    assign out_val = forced_q ? force_val : sched_val;
`else
    assign forced  = 1'b0;
    assign out_val = sched_val;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i] <= '0;
                rem_q[i] <= '0;
            end
            head      <= '0;
            wr        <= '0;
            count     <= '0;
            sched_val <= RESET_VAL;
            err       <= 1'b0;
`ifdef SCHED_FORCE_EN
            forced_q  <= 1'b0;
            force_val <= RESET_VAL;
`endif
        end else begin
            err   <= 1'b0;
            head  <= head_pp;
            count <= count_pp;
            for (int i = 0; i < DEPTH; i++) begin
                if (rem_q[i] > DLY_ONE) begin
                    rem_q[i] <= rem_q[i] - DLY_ONE;
                end
            end
            if (fire) begin
                sched_val <= val_q[head];
            end

            // Requests act on the post-pop queue; later writes override the fire.
            if (accept) begin
                case (req_mode)
                    MODE_NODELAY: begin
                        sched_val <= req_value;
                        head      <= wr;
                        count     <= '0;
                    end
                    MODE_INERTIAL: begin
                        if (direct) begin
                            sched_val <= req_value;
                            head      <= wr;
                            count     <= '0;
                        end else begin
                            val_q[wr] <= req_value;
                            rem_q[wr] <= rem_init;
                            head      <= wr;
                            wr        <= wr + PTR_ONE;
                            count     <= CNT_ONE;
                        end
                    end
                    MODE_TRANSPORT: begin
                        if (late) begin
                            err <= 1'b1;
                        end else if ((count_pp == '0) && direct) begin
                            sched_val <= req_value;
                        end else begin
                            val_q[wr] <= req_value;
                            rem_q[wr] <= rem_init;
                            wr        <= wr + PTR_ONE;
                            count     <= count_pp + CNT_ONE;
                        end
                    end
                    MODE_CANCEL: begin
                        if (count_pp == '0) begin
                            err <= 1'b1;
                        end else begin
                            wr    <= tail;
                            count <= count_pp - CNT_ONE;
                        end
                    end
`ifdef SCHED_FORCE_EN
                    MODE_FORCE: begin
                        force_val <= req_value;
                        forced_q  <= 1'b1;
                    end
                    MODE_RELEASE: begin
                        if (forced_q) begin
                            forced_q <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
`else
                    MODE_FORCE, MODE_RELEASE: begin
                        err <= 1'b1;
                    end
`endif
                    default: begin
                        err <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
